// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding controller for the five-stage RV32 pipeline: EX/MEM/WB
// operand forwarding, load-use, redirect, data-memory wait and multi-cycle EX stalls.
module hazard_unit_mc #(
    parameter int XLEN       = 32,
    parameter int NRD        = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*5-1:0]      rR_ID,
    input  logic [NRD-1:0]        rD_used,
    input  logic [4:0]            wR_EX,
    input  logic [4:0]            wR_MEM,
    input  logic [4:0]            wR_WB,
    input  logic                  rf_we_EX,
    input  logic                  rf_we_MEM,
    input  logic                  rf_we_WB,
    input  logic [XLEN-1:0]       wD_EX,
    input  logic [XLEN-1:0]       wD_MEM,
    input  logic [XLEN-1:0]       wD_WB,
    input  logic                  ex_is_load,
    input  logic                  npc_op,
    input  logic                  mc_start,
    input  logic                  mc_done,
    input  logic                  mem_load_MEM,
    input  logic                  dram_ready,
    output logic                  keep_PC,
    output logic                  keep_IF_ID,
    output logic                  keep_ID_EX,
    output logic                  keep_EX_MEM,
    output logic                  flush_IF_ID,
    output logic                  flush_ID_EX,
    output logic                  flush_EX_MEM,
    output logic                  flush_MEM_WB,
    output logic [NRD-1:0]        fwd_op,
    output logic [NRD*XLEN-1:0]   fwd_data,
    output logic                  mc_err,
    output logic [CNT_W-1:0]      stall_cnt
);
    localparam int              BW        = $clog2(MC_TIMEOUT + 1);
    localparam logic [BW-1:0]   TIMEOUT_V = BW'(MC_TIMEOUT);

    typedef enum logic [0:0] {IDLE = 1'b0, MC_BUSY = 1'b1} state_t;

    state_t             state_r, state_s;
    logic [BW-1:0]      busy_cnt_r, busy_cnt_s;
    logic               mc_err_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [NRD-1:0]     ex_hit_s, mem_hit_s, wb_hit_s;
    logic               ex_sup_s, mem_wait_s, timeout_s, mc_stall_s, load_use_s;

    assign ex_sup_s   = ex_is_load || (mc_start && !mc_done);
    assign mem_wait_s = mem_load_MEM && !dram_ready;
    assign timeout_s  = (state_r == MC_BUSY) && (busy_cnt_r == TIMEOUT_V);
    // A timed-out op releases the pipeline even though mc_start is still high.
    assign mc_stall_s = ((state_r == MC_BUSY) || mc_start) && !mc_done && !timeout_s;
    assign load_use_s = (|ex_hit_s) && ex_is_load;

    // Per-port register-index match against each producing stage
    always_comb begin
        ex_hit_s  = '0;
        mem_hit_s = '0;
        wb_hit_s  = '0;
        for (int i = 0; i < NRD; i++) begin
            ex_hit_s[i]  = rf_we_EX  && rD_used[i] && (wR_EX  == rR_ID[5*i +: 5]) && (wR_EX  != 5'd0);
            mem_hit_s[i] = rf_we_MEM && rD_used[i] && (wR_MEM == rR_ID[5*i +: 5]) && (wR_MEM != 5'd0);
            wb_hit_s[i]  = rf_we_WB  && rD_used[i] && (wR_WB  == rR_ID[5*i +: 5]) && (wR_WB  != 5'd0);
        end
    end

    // Forwarding mux, youngest producer wins
    always_comb begin
        fwd_op   = '0;
        fwd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ex_hit_s[i] && !ex_sup_s) begin
                fwd_op[i]                = 1'b1;
                fwd_data[XLEN*i +: XLEN] = wD_EX;
            end else if (mem_hit_s[i]) begin
                fwd_op[i]                = 1'b1;
                fwd_data[XLEN*i +: XLEN] = wD_MEM;
            end else if (wb_hit_s[i]) begin
                fwd_op[i]                = 1'b1;
                fwd_data[XLEN*i +: XLEN] = wD_WB;
            end else begin
                fwd_op[i]                = 1'b0;
                fwd_data[XLEN*i +: XLEN] = '0;
            end
        end
    end

    // Prioritised keep/flush generation
    always_comb begin
        keep_PC      = 1'b0;
        keep_IF_ID   = 1'b0;
        keep_ID_EX   = 1'b0;
        keep_EX_MEM  = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        if (mem_wait_s) begin
            keep_PC      = 1'b1;
            keep_IF_ID   = 1'b1;
            keep_ID_EX   = 1'b1;
            keep_EX_MEM  = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (mc_stall_s) begin
            keep_PC      = 1'b1;
            keep_IF_ID   = 1'b1;
            keep_ID_EX   = 1'b1;
            flush_EX_MEM = 1'b1;
        end else if (load_use_s) begin
            keep_PC      = 1'b1;
            keep_IF_ID   = 1'b1;
            flush_ID_EX  = 1'b1;
        end else if (npc_op) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
        end else begin
            keep_PC      = 1'b0;
        end
    end

    // Multi-cycle FSM next state and busy-cycle counter
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mc_start && !mc_done && !mem_wait_s) state_s = MC_BUSY;
                else                                     state_s = IDLE;
            end
            MC_BUSY: begin
                if (mc_done || timeout_s) state_s = IDLE;
                else                      state_s = MC_BUSY;
            end
            default: state_s = IDLE;
        endcase
        if ((state_r == MC_BUSY) && (state_s == MC_BUSY)) busy_cnt_s = busy_cnt_r + BW'(1);
        else                                              busy_cnt_s = '0;
    end

    // State, busy counter, sticky error and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_cnt_r  <= '0;
            mc_err_r    <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            busy_cnt_r <= busy_cnt_s;
            if (timeout_s && !mc_done) mc_err_r <= 1'b1;
            if (keep_PC && (stall_cnt_r != {CNT_W{1'b1}})) stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    assign mc_err    = mc_err_r;
    assign stall_cnt = stall_cnt_r;
endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard and forwarding controller for the five-stage RV32 pipeline. It forwards EX, MEM and WB results to NRD ID-stage read ports. It handles load-use, control hazards, variable-latency data memory and multi-cycle EX operations (mul/div). A registered FSM plus counters drive the per-stage keep/flush controls, a timeout error flag and a stall performance counter.

## Interface
- XLEN, 32, data width
- NRD, 2, number of ID read ports (1..4)
- MC_TIMEOUT, 64, max MC_BUSY cycles before error (≥2)
- CNT_W, 32, stall counter width
- clk  in  1  clock, all state rising-edge
- rst  in  1  reset, asynchronous, active-high
- rR_ID  in  NRD*5  ID source register indices, port i at [5i+4:5i]
- rD_used  in  NRD  port i actually read by the ID instruction
- wR_EX / wR_MEM / wR_WB  in  5 each  destination indices
- rf_we_EX / rf_we_MEM / rf_we_WB  in  1 each  write enables
- wD_EX / wD_MEM / wD_WB  in  XLEN each  candidate write data
- ex_is_load  in  1  EX instruction is a load
- npc_op  in  1  branch/jump taken, resolved in EX
- mc_start  in  1  EX holds a multi-cycle op (level while op sits in EX)
- mc_done  in  1  multi-cycle result valid on wD_EX this cycle
- mem_load_MEM  in  1  MEM holds a load
- dram_ready  in  1  load data valid this cycle
- keep_PC, keep_IF_ID, keep_ID_EX, keep_EX_MEM  out  1 each  hold register
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  insert bubble
- fwd_op  out  NRD  port i takes forwarded data
- fwd_data  out  NRD*XLEN  forwarded value, port i at [XLEN*i+XLEN-1:XLEN*i]
- mc_err  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  cycles with keep_PC=1

## Operation
- Match per port i and stage s: wR_s==rR_i, rf_we_s, rD_used[i], wR_s!=0.
- Forwarding priority EX > MEM > WB. fwd_op[i]=any match. fwd_data[i]=0 when no match.
- EX match is suppressed (falls to MEM/WB) when ex_is_load=1, or when mc_start=1 and mc_done=0.
- FSM states: IDLE, MC_BUSY.
  - IDLE→MC_BUSY: mc_start & !mc_done & !mem_wait.
  - MC_BUSY→IDLE: mc_done, or busy count reaching MC_TIMEOUT (sets mc_err).
- mem_wait = mem_load_MEM & !dram_ready.
- Stall conditions, highest priority first:
  - mem_wait: keep_PC, keep_IF_ID, keep_ID_EX, keep_EX_MEM=1; flush_MEM_WB=1. npc_op ignored.
  - mc_stall = (MC_BUSY or mc_start) & !mc_done: keep_PC, keep_IF_ID, keep_ID_EX=1; flush_EX_MEM=1. npc_op ignored.
  - load_use = raw EX match on any port & ex_is_load: keep_PC, keep_IF_ID=1; flush_ID_EX=1.
  - redirect = npc_op with none of the above: flush_IF_ID, flush_ID_EX=1.
- All other keep/flush outputs are 0.
- Busy counter: cleared in IDLE, +1 per MC_BUSY cycle. Timeout forces MC_BUSY exit and releases the stall that cycle.
- stall_cnt: +1 per cycle with keep_PC=1, saturates at all-ones.
- mc_err: cleared only by rst.

## Timing
- Forwarding and keep/flush outputs are combinational from inputs and the current state. Zero latency, same cycle as detection.
- State, busy counter, mc_err and stall_cnt update on the clk edge.
- rst asserted (any time, mid-stall included): state=IDLE, counter=0, mc_err=0, stall_cnt=0. All outputs then equal the combinational function of inputs in IDLE.
- Multi-cycle op enters EX at cycle N with mc_done=0: stalls N..M-1, where M is the mc_done cycle. Release at M; IDLE at M+1.
- mc_start & mc_done in the same cycle: no stall, no state change.
- mem_wait during MC_BUSY: full freeze. The busy counter still advances, and mc_done is still honoured for the state transition.
- Load-use costs exactly 1 bubble. With dram_ready low, mem_wait extends the stall.

## Test plan
- EX x5=0xA, MEM x5=0xB, WB x5=0xC, rR port0=5 -> fwd_op[0]=1, data 0xA. With rf_we_EX=0 -> 0xB. With rR=0 -> fwd_op=0, data 0.
- Load to x7 in EX, ID reads x7 on port1 -> keep_PC, keep_IF_ID, flush_ID_EX=1 for 1 cycle. fwd EX suppressed. stall_cnt +1.
- mc_start high cycles 10..14, mc_done at 14 -> keep_PC 10..13, flush_EX_MEM 10..13, released at 14, stall_cnt=4.
- mc_start held, mc_done never asserted, MC_TIMEOUT=64 -> mc_err=1 after timeout, stall released; rst clears mc_err.
- mem_load_MEM=1, dram_ready low 3 cycles with npc_op=1 -> full freeze 3 cycles, flush_MEM_WB=1, no flush_IF_ID. Redirect flush occurs in the cycle dram_ready=1.
- rst pulsed mid-MC_BUSY -> next cycle IDLE, counters 0, outputs per IDLE rules.
